// File: rtl/api_work_arb_pkg.sv
// Shared constants for the API work-source arbiter.
//   API_REQ_NUM / API_WORK_LEN / API_TXFIFO_DEPTH / API_CNT_W : default sizing
//   ARB_* : arbiter FSM state encoding
//   api_rr_next : round-robin pointer advance with wrap at n
package api_work_arb_pkg;

  localparam int API_REQ_NUM      = 2;
  localparam int API_WORK_LEN     = 23;   // 736-bit work unit in 32-bit words
  localparam int API_TXFIFO_DEPTH = 512;
  localparam int API_CNT_W        = 10;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_SEND = 2'd1;
  localparam logic [1:0] ARB_GAP  = 2'd2;

  function automatic logic [2:0] api_rr_next(input logic [2:0] id, input int n);
    return (int'(id) == n - 1) ? 3'd0 : id + 3'd1;
  endfunction

endpackage

// File: rtl/api_rr_pick.sv
// Combinational round-robin pick: lowest requesting index at or after ptr_i,
// wrapping at N. Rotate so ptr_i lands at bit 0, priority-encode, rotate back.
//   req_i  : request vector
//   ptr_i  : round-robin start index (< N)
//   any_o  : at least one request
//   idx_o  : winner index (valid when any_o)
module api_rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [2:0]   ptr_i,
  output logic         any_o,
  output logic [2:0]   idx_o
);

  logic [N-1:0] rot;
  logic [3:0]   pos;
  logic [2:0]   off;
  logic         found;
  logic [3:0]   sum;

  // rot[k] = req_i[(ptr_i + k) mod N]
  always_comb begin
    rot = '0;
    pos = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr_i} + 4'(k);
      if (pos >= 4'(N)) pos = pos - 4'(N);
      for (int i = 0; i < N; i++)
        if (pos == 4'(i)) rot[k] = req_i[i];
    end
  end

  always_comb begin
    off   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++)
      if (!found && rot[k]) begin
        off   = 3'(k);
        found = 1'b1;
      end
  end

  always_comb begin
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= 4'(N)) sum = sum - 4'(N);
    idx_o = sum[2:0];
  end

  assign any_o = |req_i;

endmodule

// File: rtl/api_work_arb.sv
// Packet-atomic round-robin arbiter feeding the API tx FIFO. A source is
// granted for exactly WORK_LEN words, and only when the FIFO can hold the
// whole packet, so the consumer never sees a torn work unit.
//   clk, rst_n      : clock, async active-low reset
//   flush           : sync abort/clear (pulsed with the FIFO flush)
//   enable          : allows new grants (ignored mid-packet)
//   req_valid/data  : per-source word valid / 32-bit word (source i at [32i+:32])
//   req_ready       : per-source word accepted this cycle
//   txfifo_push/din : registered FIFO write strobe / data
//   txcnt           : FIFO data count
//   busy, grant_id, pkt_cnt : status
import api_work_arb_pkg::*;

module api_work_arb #(
  parameter int REQ_NUM    = API_REQ_NUM,
  parameter int WORK_LEN   = API_WORK_LEN,
  parameter int FIFO_DEPTH = API_TXFIFO_DEPTH,
  parameter int CNT_W      = API_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  enable,
  input  logic [REQ_NUM-1:0]    req_valid,
  input  logic [32*REQ_NUM-1:0] req_data,
  output logic [REQ_NUM-1:0]    req_ready,
  output logic                  txfifo_push,
  output logic [31:0]           txfifo_din,
  input  logic [CNT_W-1:0]      txcnt,
  output logic                  busy,
  output logic [2:0]            grant_id,
  output logic [15:0]           pkt_cnt
);

  localparam int CW = (WORK_LEN > 1) ? $clog2(WORK_LEN + 1) : 1;

  logic [1:0]    state_q, state_d;
  logic [2:0]    grant_q, grant_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   pkt_q, pkt_d;
  logic          busy_q, busy_d;
  logic          push_q, push_d;
  logic [31:0]   din_q, din_d;

  logic          pick_any;
  logic [2:0]    pick_idx;
  logic          sel_valid;
  logic [31:0]   sel_data;
  logic          space_ok;

  api_rr_pick #(.N(REQ_NUM)) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  // One extra bit so a count above the depth cannot wrap into "lots of room".
  logic [CNT_W:0] depth_w, tx_w;
  assign depth_w  = (CNT_W+1)'(FIFO_DEPTH);
  assign tx_w     = {1'b0, txcnt};
  assign space_ok = (tx_w <= depth_w) && ((depth_w - tx_w) >= (CNT_W+1)'(WORK_LEN));

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < REQ_NUM; i++)
      if (grant_q == 3'(i)) begin
        sel_valid = req_valid[i];
        sel_data  = req_data[32*i +: 32];
      end
  end

  // Ready is suppressed during flush so no word is consumed and then dropped.
  always_comb begin
    req_ready = '0;
    if (state_q == ARB_SEND && !flush)
      for (int i = 0; i < REQ_NUM; i++)
        req_ready[i] = (grant_q == 3'(i)) & req_valid[i];
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    pkt_d   = pkt_q;
    busy_d  = busy_q;
    push_d  = 1'b0;
    din_d   = din_q;
    if (flush) begin
      state_d = ARB_IDLE;
      grant_d = '0;
      ptr_d   = '0;
      cnt_d   = '0;
      pkt_d   = '0;
      busy_d  = 1'b0;
      din_d   = '0;
    end else begin
      case (state_q)
        ARB_IDLE:
          if (enable && pick_any && space_ok) begin
            state_d = ARB_SEND;
            grant_d = pick_idx;
            cnt_d   = '0;
            busy_d  = 1'b1;
          end
        ARB_SEND:
          if (sel_valid) begin
            push_d = 1'b1;
            din_d  = sel_data;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WORK_LEN - 1)) begin
              pkt_d   = pkt_q + 16'd1;
              ptr_d   = api_rr_next(grant_q, REQ_NUM);
              state_d = ARB_GAP;
            end
          end
        // Gives txcnt a cycle to see the last push before the next space check.
        ARB_GAP: begin
          busy_d  = 1'b0;
          state_d = ARB_IDLE;
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      pkt_q   <= '0;
      busy_q  <= 1'b0;
      push_q  <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      pkt_q   <= pkt_d;
      busy_q  <= busy_d;
      push_q  <= push_d;
      din_q   <= din_d;
    end
  end

  assign txfifo_push = push_q;
  assign txfifo_din  = din_q;
  assign busy        = busy_q;
  assign grant_id    = grant_q;
  assign pkt_cnt     = pkt_q;

endmodule

// File: tb/tb_api_work_arb.sv
module tb_api_work_arb;
  localparam int N = 2, WL = 23, DEPTH = 512, CW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic enable = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [32*N-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic txfifo_push;
  logic [31:0] txfifo_din;
  logic [CW-1:0] txcnt = '0;
  logic busy;
  logic [2:0] grant_id;
  logic [15:0] pkt_cnt;

  api_work_arb #(.REQ_NUM(N), .WORK_LEN(WL), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .txfifo_push(txfifo_push), .txfifo_din(txfifo_din), .txcnt(txcnt),
    .busy(busy), .grant_id(grant_id), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [31:0] src_next[N], src_end[N];
  logic src_on[N];
  int cyc, busy_cnt;
  int acc_src[$], acc_cyc[$], push_cyc[$];
  logic [31:0] acc_data[$], push_data[$];

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = src_on[i] && (src_next[i] != src_end[i]);
      req_data[32*i +: 32] = src_next[i];
    end
  endtask

  task automatic src_set(input int i, input logic on, input logic [31:0] base, input logic [31:0] lim);
    src_on[i] = on; src_next[i] = base; src_end[i] = lim;
  endtask

  // One clock: observe at negedge, advance sources just after posedge.
  task automatic step();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = req_ready & req_valid;
    for (int i = 0; i < N; i++)
      if (acc[i]) begin acc_src.push_back(i); acc_data.push_back(src_next[i]); acc_cyc.push_back(cyc); end
    if (txfifo_push) begin push_data.push_back(txfifo_din); push_cyc.push_back(cyc); end
    if (busy) busy_cnt++;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) if (acc[i]) src_next[i]++;
    cyc++;
    drive();
  endtask

  task automatic clear_logs();
    acc_src.delete(); acc_cyc.delete(); acc_data.delete();
    push_data.delete(); push_cyc.delete();
    cyc = 0; busy_cnt = 0;
  endtask

  task automatic do_reset();
    flush = 1'b0;
    rst_n = 1'b0;
    drive();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic test_reset();
    src_set(0, 1'b1, 32'h1000, 32'hFFFF_FFFF); src_set(1, 1'b1, 32'h2000, 32'hFFFF_FFFF);
    enable = 1'b1; txcnt = '0; rst_n = 1'b0; drive();
    @(negedge clk);
    total++; if (txfifo_push !== 1'b0) begin bad++; $display("FAIL reset_push got=%b want=0", txfifo_push); end
    total++; if (txfifo_din !== 32'h0) begin bad++; $display("FAIL reset_din got=%h want=0", txfifo_din); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (grant_id !== 3'd0) begin bad++; $display("FAIL reset_grant got=%0d want=0", grant_id); end
    total++; if (pkt_cnt !== 16'd0) begin bad++; $display("FAIL reset_pkt got=%0d want=0", pkt_cnt); end
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b want=00", req_ready); end
  endtask

  task automatic test_single();
    src_set(0, 1'b1, 32'h1000, 32'h1017); src_set(1, 1'b0, 32'h2000, 32'h2000);
    enable = 1'b1; txcnt = '0;
    do_reset();
    repeat (30) step();
    total++; if (push_data.size() != WL) begin bad++; $display("FAIL single_npush got=%0d want=%0d", push_data.size(), WL); end
    for (int k = 0; k < push_data.size() && k < WL; k++) begin
      total++; if (push_data[k] !== 32'h1000 + 32'(k)) begin bad++; $display("FAIL single_din[%0d] got=%h want=%h", k, push_data[k], 32'h1000 + 32'(k)); end
    end
    for (int k = 0; k < push_cyc.size() && k < acc_cyc.size(); k++) begin
      total++; if (push_cyc[k] != acc_cyc[k] + 1) begin bad++; $display("FAIL single_lat[%0d] got=%0d want=%0d", k, push_cyc[k], acc_cyc[k] + 1); end
    end
    total++; if (pkt_cnt !== 16'd1) begin bad++; $display("FAIL single_pkt got=%0d want=1", pkt_cnt); end
    total++; if (busy_cnt != 24) begin bad++; $display("FAIL single_busy got=%0d want=24", busy_cnt); end
  endtask

  task automatic test_back_to_back();
    int p; logic [31:0] exp;
    src_set(0, 1'b1, 32'h1000, 32'hFFFF_FFFF); src_set(1, 1'b1, 32'h2000, 32'hFFFF_FFFF);
    enable = 1'b1; txcnt = '0;
    do_reset();
    repeat (100) step();
    total++; if (pkt_cnt !== 16'd4) begin bad++; $display("FAIL b2b_pkt got=%0d want=4", pkt_cnt); end
    total++; if (acc_src.size() != 4*WL) begin bad++; $display("FAIL b2b_nacc got=%0d want=%0d", acc_src.size(), 4*WL); end
    total++; if (push_data.size() != 4*WL) begin bad++; $display("FAIL b2b_npush got=%0d want=%0d", push_data.size(), 4*WL); end
    for (int k = 0; k < acc_src.size() && k < 4*WL; k++) begin
      p = k / WL;
      exp = ((p % 2) ? 32'h2000 : 32'h1000) + 32'((p / 2) * WL + k % WL);
      total++; if (acc_src[k] != p % 2) begin bad++; $display("FAIL b2b_src[%0d] got=%0d want=%0d", k, acc_src[k], p % 2); end
      total++; if (acc_data[k] !== exp) begin bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", k, acc_data[k], exp); end
    end
    total++; if (busy_cnt != 4*(WL+1)) begin bad++; $display("FAIL b2b_busy got=%0d want=%0d", busy_cnt, 4*(WL+1)); end
  endtask

  task automatic test_space();
    src_set(0, 1'b1, 32'h5000, 32'hFFFF_FFFF); src_set(1, 1'b0, 32'h0, 32'h0);
    enable = 1'b1; txcnt = 10'd1000;
    do_reset();
    repeat (4) step();
    total++; if (busy !== 1'b0 || acc_src.size() != 0) begin bad++; $display("FAIL space_over got=busy%b/acc%0d want=0/0", busy, acc_src.size()); end
    txcnt = 10'd490;
    repeat (4) step();
    total++; if (busy !== 1'b0 || acc_src.size() != 0) begin bad++; $display("FAIL space_490 got=busy%b/acc%0d want=0/0", busy, acc_src.size()); end
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL space_ready got=%b want=00", req_ready); end
    txcnt = 10'd489;
    step();
    total++; if (busy !== 1'b1 || grant_id !== 3'd0) begin bad++; $display("FAIL space_489_grant got=busy%b/id%0d want=1/0", busy, grant_id); end
    step();
    total++; if (acc_src.size() != 1) begin bad++; $display("FAIL space_first_acc got=%0d want=1", acc_src.size()); end
  endtask

  task automatic test_stall();
    src_set(0, 1'b0, 32'h1000, 32'hFFFF_FFFF); src_set(1, 1'b1, 32'h2000, 32'h2017);
    enable = 1'b1; txcnt = '0;
    do_reset();
    step();
    src_on[0] = 1'b1; drive();
    for (int k = 0; k < 40 && acc_src.size() < 6; k++) step();
    total++; if (acc_src.size() != 6) begin bad++; $display("FAIL stall_pre got=%0d want=6", acc_src.size()); end
    src_on[1] = 1'b0; drive();
    repeat (10) step();
    src_on[1] = 1'b1; drive();
    for (int k = 0; k < 60 && pkt_cnt != 16'd1; k++) step();
    step();
    total++; if (pkt_cnt !== 16'd1) begin bad++; $display("FAIL stall_pkt got=%0d want=1", pkt_cnt); end
    total++; if (grant_id !== 3'd1) begin bad++; $display("FAIL stall_grant got=%0d want=1", grant_id); end
    total++; if (acc_src.size() != WL) begin bad++; $display("FAIL stall_nacc got=%0d want=%0d", acc_src.size(), WL); end
    for (int k = 0; k < acc_src.size(); k++) begin
      total++; if (acc_src[k] != 1) begin bad++; $display("FAIL stall_src[%0d] got=%0d want=1", k, acc_src[k]); end
    end
    total++; if (push_data.size() != WL) begin bad++; $display("FAIL stall_npush got=%0d want=%0d", push_data.size(), WL); end
    for (int k = 0; k < push_data.size() && k < WL; k++) begin
      total++; if (push_data[k] !== 32'h2000 + 32'(k)) begin bad++; $display("FAIL stall_din[%0d] got=%h want=%h", k, push_data[k], 32'h2000 + 32'(k)); end
    end
    if (push_cyc.size() > 6) begin
      total++; if (push_cyc[6] - push_cyc[5] != 11) begin bad++; $display("FAIL stall_gap got=%0d want=11", push_cyc[6] - push_cyc[5]); end
    end
  endtask

  task automatic test_flush();
    src_set(0, 1'b1, 32'h3000, 32'hFFFF_FFFF); src_set(1, 1'b0, 32'h0, 32'h0);
    enable = 1'b1; txcnt = '0;
    do_reset();
    for (int k = 0; k < 40 && acc_src.size() < 12; k++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++; if (acc_src.size() != 12) begin bad++; $display("FAIL flush_acc got=%0d want=12", acc_src.size()); end
    total++; if (txfifo_push !== 1'b0 || txfifo_din !== 32'h0) begin bad++; $display("FAIL flush_out got=%b/%h want=0/0", txfifo_push, txfifo_din); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b want=0", busy); end
    total++; if (pkt_cnt !== 16'd0) begin bad++; $display("FAIL flush_pkt0 got=%0d want=0", pkt_cnt); end
    clear_logs();
    for (int k = 0; k < 60 && pkt_cnt != 16'd1; k++) step();
    total++; if (pkt_cnt !== 16'd1) begin bad++; $display("FAIL flush_pkt1 got=%0d want=1", pkt_cnt); end
    total++; if (acc_src.size() != WL) begin bad++; $display("FAIL flush_nacc got=%0d want=%0d", acc_src.size(), WL); end
    if (acc_data.size() > 0) begin
      total++; if (acc_data[0] !== 32'h300C) begin bad++; $display("FAIL flush_first got=%h want=300c", acc_data[0]); end
    end
  endtask

  task automatic test_async_reset();
    src_set(0, 1'b1, 32'h4000, 32'hFFFF_FFFF); src_set(1, 1'b0, 32'h0, 32'h0);
    enable = 1'b1; txcnt = '0;
    do_reset();
    for (int k = 0; k < 40 && acc_src.size() < 5; k++) step();
    total++; if (txfifo_push !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL arst_pre got=%b/%b want=1/1", txfifo_push, busy); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (txfifo_push !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL arst_now got=%b/%b want=0/0", txfifo_push, busy); end
    total++; if (req_ready !== 2'b00 || txfifo_din !== 32'h0) begin bad++; $display("FAIL arst_ready got=%b/%h want=00/0", req_ready, txfifo_din); end
    @(posedge clk); #1;
    total++; if (txfifo_push !== 1'b0) begin bad++; $display("FAIL arst_edge got=%b want=0", txfifo_push); end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_space();
    test_stall();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
